gray_updown_counter: RTL and testbench
======================================

// Module: gray_updown_counter
//
// PURPOSE
// Parametrised synchronous up/down counter that holds its count in binary and
// presents both the binary value and its registered Gray-code equivalent.
// Parallel load accepts the load value in Gray or binary, selected per load.
// Successor to the 4-bit combinational Gray-to-binary converter: used for
// position and pointer tracking where a Gray-coded output must cross domains.
//
// PARAMETERS
// WIDTH  4  counter and data width in bits; legal range is 2 or more.
// WRAP   1  1: the count wraps at the ends; 0: the count saturates at 0 and 2^WIDTH-1.
//
// PORTS
// clk       in   1      rising-edge clock.
// rst       in   1      synchronous reset, active-high.
// en        in   1      count enable; one step per cycle while high.
// up        in   1      direction: 1 counts up, 0 counts down; sampled with en.
// load      in   1      parallel load strobe.
// load_fmt  in   1      1: load_val is Gray code; 0: load_val is binary.
// load_val  in   WIDTH  value to load.
// bin       out  WIDTH  registered count in binary.
// G         out  WIDTH  registered count in Gray code; G == bin ^ (bin >> 1) on every cycle.
// tc        out  1      registered terminal-count pulse.
//
// BEHAVIOUR
// - One clock domain. All outputs are registered and all inputs are sampled on the rising clk edge.
// - Priority at each edge: rst, then load, then en; otherwise all state holds.
// - rst=1: bin=0, G=0, tc=0 at that edge. This overrides load and en, and takes effect mid-count.
// - Load with load_fmt=0: bin <= load_val, and G <= load_val ^ (load_val >> 1).
// - Load with load_fmt=1: G <= load_val.
//   - bin <= Gray-to-binary of load_val: bin[WIDTH-1] = g[WIDTH-1], then bin[i] = bin[i+1] ^ g[i].
//   - The conversion completes within the load cycle, so there is no extra latency.
// - load has priority over en: when both are high, only the load happens and no step is taken.
//   tc is 0 on a load edge.
// - Step, when en=1 and load=0:
//   - up=1: bin <= bin + 1. up=0: bin <= bin - 1. Arithmetic is modulo 2^WIDTH.
//   - The terminal value is 2^WIDTH-1 when counting up and 0 when counting down.
//   - Step from the terminal value with WRAP=1: the count wraps (max goes to 0, or 0 goes to max), and tc=1 for that one cycle.
//   - Step from the terminal value with WRAP=0: the count holds at the terminal value, and tc=1 for each cycle the step is attempted.
//   - Any other step: tc=0.
// - en=0 and load=0: bin and G hold, and tc=0.
// - Output latency: a value is visible on bin and G in the cycle right after the edge that produced it.
//   tc aligns with that same updated value.
// - Gray property: successive up or down steps change exactly one bit of G, including across a wrap.
// - Direction may change on any cycle. A reversal is an ordinary step with no dead cycle.
//
// TESTING
// 1. Reset: drive rst=1 with en=1 and load=1 -> bin=0000, G=0000, tc=0. Repeat mid-count -> same values on the next edge.
// 2. WIDTH=4, WRAP=1, up=1, en=1 for 16 cycles from 0 -> G must follow
//    0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000,
//    then 0000 with tc=1 for exactly one cycle. Check one-bit change per step.
// 3. up=0 from bin=0000, WRAP=1 -> bin=1111, G=1000, tc=1. Next step -> bin=1110, G=1001, tc=0.
// 4. Load with load_fmt=1, load_val=1011 -> bin=1101, G=1011. Load with load_fmt=0, load_val=0110 -> bin=0110, G=0101.
//    Load together with en=1 -> only the loaded value appears, with no step and tc=0.
// 5. WRAP=0, bin=1111, up=1, en=1 for 3 cycles -> bin stays 1111, G stays 1000, tc=1 on all 3 cycles.
//    Then up=0 -> bin=1110, tc=0.
// 6. en=0 for 5 cycles at bin=0101 -> bin and G hold, tc=0. Toggling up with en=0 -> no change.

Source files
------------

// File: rtl/gray_updown_counter_if.sv
// Control and result bundle for gray_updown_counter: the master drives the
// count/load controls, the slave (the counter) returns binary, Gray and tc.
interface gray_updown_counter_if #(
  parameter int WIDTH = 4
) ();
  logic             en;
  logic             up;
  logic             load;
  logic             load_fmt;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] bin;
  logic [WIDTH-1:0] G;
  logic             tc;

  modport master (
    output en, up, load, load_fmt, load_val,
    input  bin, G, tc
  );

  modport slave (
    input  en, up, load, load_fmt, load_val,
    output bin, G, tc
  );
endinterface

// File: rtl/gray_updown_counter.sv
// Up/down counter holding its count in binary with a registered Gray copy;
// loads accept binary or Gray, and WRAP selects wrap-around or saturation.
module gray_updown_counter #(
  parameter int WIDTH = 4,
  parameter int WRAP  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  gray_updown_counter_if.slave  bus
);

  localparam logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO_VAL = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_VAL  = {{(WIDTH-1){1'b0}}, 1'b1};

  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down; purely combinational so a Gray load costs no latency.
  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] g_q,   g_d;
  logic             tc_q,  tc_d;
  logic             at_term_s;

  // Next-state: load beats step, step beats hold.
  always_comb begin
    bin_d     = bin_q;
    g_d       = g_q;
    tc_d      = 1'b0;
    at_term_s = 1'b0;
    if (bus.load) begin
      if (bus.load_fmt) begin
        bin_d = gray2bin(bus.load_val);
        g_d   = bus.load_val;
      end else begin
        bin_d = bus.load_val;
        g_d   = bin2gray(bus.load_val);
      end
    end else if (bus.en) begin
      at_term_s = bus.up ? (bin_q == MAX_VAL) : (bin_q == ZERO_VAL);
      tc_d      = at_term_s;
      if (at_term_s && (WRAP == 0)) begin
        bin_d = bin_q;
      end else if (bus.up) begin
        bin_d = bin_q + ONE_VAL;
      end else begin
        bin_d = bin_q - ONE_VAL;
      end
      g_d = bin2gray(bin_d);
    end else begin
      bin_d = bin_q;
      g_d   = g_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q <= ZERO_VAL;
      g_q   <= ZERO_VAL;
      tc_q  <= 1'b0;
    end else begin
      bin_q <= bin_d;
      g_q   <= g_d;
      tc_q  <= tc_d;
    end
  end

  assign bus.bin = bin_q;
  assign bus.G   = g_q;
  assign bus.tc  = tc_q;

endmodule

// File: tb/tb_gray_updown_counter.sv
// Drives a wrapping and a saturating counter with the same stimulus and checks
// both against an arithmetic reference model plus directed expected values.
module tb_gray_updown_counter;
  localparam int W    = 4;
  localparam int MAXV = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         rst_v, en_v, up_v, load_v, fmt_v;
  logic [W-1:0] val_v;

  gray_updown_counter_if #(.WIDTH(W)) ifw ();
  gray_updown_counter_if #(.WIDTH(W)) ifs ();

  assign rst          = rst_v;
  assign ifw.en       = en_v;
  assign ifw.up       = up_v;
  assign ifw.load     = load_v;
  assign ifw.load_fmt = fmt_v;
  assign ifw.load_val = val_v;
  assign ifs.en       = en_v;
  assign ifs.up       = up_v;
  assign ifs.load     = load_v;
  assign ifs.load_fmt = fmt_v;
  assign ifs.load_val = val_v;

  gray_updown_counter #(.WIDTH(W), .WRAP(1)) dut_w (.clk(clk), .rst(rst), .bus(ifw));
  gray_updown_counter #(.WIDTH(W), .WRAP(0)) dut_s (.clk(clk), .rst(rst), .bus(ifs));

  int n_checks = 0;
  int n_fail   = 0;
  int exp_b [2];
  int exp_tc[2];

  // Reference: Gray decode by search over all codes.
  function automatic int g2b(input int g);
    for (int b = 0; b <= MAXV; b++) begin
      if ((b ^ (b >> 1)) == g) return b;
    end
    return -1;
  endfunction

  function automatic int b2g(input int b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_step(input int d, input bit wrap);
    if (rst_v) begin
      exp_b[d] = 0; exp_tc[d] = 0;
    end else if (load_v) begin
      exp_b[d]  = fmt_v ? g2b(int'(val_v)) : int'(val_v);
      exp_tc[d] = 0;
    end else if (en_v) begin
      if (up_v) begin
        if (exp_b[d] == MAXV) begin
          exp_tc[d] = 1; exp_b[d] = wrap ? 0 : MAXV;
        end else begin
          exp_tc[d] = 0; exp_b[d] = exp_b[d] + 1;
        end
      end else begin
        if (exp_b[d] == 0) begin
          exp_tc[d] = 1; exp_b[d] = wrap ? MAXV : 0;
        end else begin
          exp_tc[d] = 0; exp_b[d] = exp_b[d] - 1;
        end
      end
    end else begin
      exp_tc[d] = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0, 1'b1);
    model_step(1, 1'b0);
    #1;
    chk("wrap_bin", ifw.bin, W'(exp_b[0]));
    chk("wrap_G",   ifw.G,   W'(b2g(exp_b[0])));
    chk("wrap_tc",  {3'b000, ifw.tc}, W'(exp_tc[0]));
    chk("sat_bin",  ifs.bin, W'(exp_b[1]));
    chk("sat_G",    ifs.G,   W'(b2g(exp_b[1])));
    chk("sat_tc",   {3'b000, ifs.tc}, W'(exp_tc[1]));
  endtask

  task automatic drive(input logic r, input logic e, input logic u,
                       input logic l, input logic f, input logic [W-1:0] v);
    rst_v = r; en_v = e; up_v = u; load_v = l; fmt_v = f; val_v = v;
  endtask

  logic [W-1:0] gseq [16];
  logic [W-1:0] prev_g;

  initial begin
    exp_b  = '{0, 0};
    exp_tc = '{0, 0};
    gseq = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
             4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};

    // Reset overrides load and en.
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b1010);
    tick();
    chk("rst_bin", ifw.bin, 4'b0000);
    chk("rst_G",   ifw.G,   4'b0000);
    chk("rst_tc",  {3'b000, ifw.tc}, 4'b0000);

    // Full up sequence with wrap.
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000);
    prev_g = ifw.G;
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk("seq_G", ifw.G, gseq[k % 16]);
      chk("seq_onebit", W'($countones(ifw.G ^ prev_g)), 4'b0001);
      chk("seq_tc", {3'b000, ifw.tc}, (k == 16) ? 4'b0001 : 4'b0000);
      prev_g = ifw.G;
    end

    // Mid-count reset.
    tick(); tick();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0111);
    tick();
    chk("midrst_bin", ifw.bin, 4'b0000);
    chk("midrst_G",   ifw.G,   4'b0000);

    // Down wrap from zero, then ordinary down step.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
    tick();
    chk("dn_wrap_bin", ifw.bin, 4'b1111);
    chk("dn_wrap_G",   ifw.G,   4'b1000);
    chk("dn_wrap_tc",  {3'b000, ifw.tc}, 4'b0001);
    chk("dn_sat_bin",  ifs.bin, 4'b0000);
    tick();
    chk("dn2_bin", ifw.bin, 4'b1110);
    chk("dn2_G",   ifw.G,   4'b1001);
    chk("dn2_tc",  {3'b000, ifw.tc}, 4'b0000);

    // Loads in both formats, and load beating en.
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'b1011);
    tick();
    chk("ldg_bin", ifw.bin, 4'b1101);
    chk("ldg_G",   ifw.G,   4'b1011);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0110);
    tick();
    chk("ldb_bin", ifw.bin, 4'b0110);
    chk("ldb_G",   ifw.G,   4'b0101);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b1111);
    tick();
    chk("ldpri_bin", ifw.bin, 4'b1111);
    chk("ldpri_tc",  {3'b000, ifw.tc}, 4'b0000);

    // Saturation at max, then reversal.
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("sat_hold_bin", ifs.bin, 4'b1111);
      chk("sat_hold_G",   ifs.G,   4'b1000);
      chk("sat_hold_tc",  {3'b000, ifs.tc}, 4'b0001);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
    tick();
    chk("sat_rev_bin", ifs.bin, 4'b1110);
    chk("sat_rev_tc",  {3'b000, ifs.tc}, 4'b0000);

    // Hold with en=0 while up toggles.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0101);
    tick();
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 1'b0, k[0], 1'b0, 1'b0, 4'b1100);
      tick();
      chk("hold_bin", ifw.bin, 4'b0101);
      chk("hold_G",   ifw.G,   4'b0111);
      chk("hold_tc",  {3'b000, ifw.tc}, 4'b0000);
    end

    // Randomized traffic against the model.
    for (int k = 0; k < 300; k++) begin
      drive(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
            ($urandom_range(0, 6) == 0), $urandom_range(0, 1) == 1, W'($urandom_range(0, MAXV)));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
